// File: rtl/dbus_responder.sv
// Data-bus responder: memory end of the dreq/dresp handshake, one request at a time.
// Latency: addr_ok same cycle as valid in IDLE; data_ok LATENCY+1 cycles after acceptance.
// Backpressure: addr_ok held low in WAIT/RESP; the initiator keeps valid up until accepted.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-high
//   dreq  - request {valid, addr, size, strobe, data}
//   dresp - response {addr_ok, data_ok, data}
//   busy  - high whenever the responder is not IDLE

package dbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

module dbus_responder
  import dbus_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int LATENCY        = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy
);

  localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
  // Counter only ever holds values up to LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      w_accept;
  logic                      w_wr_en;

  // Request fields frozen at acceptance; live dreq is ignored afterwards.
  logic [MEM_WORDS_LOG2-1:0] r_idx;
  logic [3:0]                r_strobe;
  logic [31:0]               r_wdata;

  // Storage is deliberately not reset so contents survive a reset.
  logic [31:0]               r_mem [0:MEM_WORDS-1];

  // Address bits outside the word index and the size field are don't-cares.
  logic                      w_unused;
  assign w_unused = ^{dreq.addr[31:MEM_WORDS_LOG2+2], dreq.addr[1:0], dreq.size};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_wr_en     = 1'b0;
    dresp       = '0;
    busy        = 1'b0;

    // Reset masks every output and blocks acceptance in the same cycle.
    if (!reset) begin
      busy = (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          dresp.addr_ok = dreq.valid;
          if (dreq.valid) begin
            w_accept = 1'b1;
            if (LATENCY == 0) begin
              w_state_nxt = S_RESP;
            end else begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          // Read comes from the array before the write lands on the leaving edge.
          dresp.data_ok = 1'b1;
          dresp.data    = r_mem[r_idx];
          w_wr_en       = 1'b1;
          w_state_nxt   = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx    <= dreq.addr[MEM_WORDS_LOG2+1:2];
      r_strobe <= dreq.strobe;
      r_wdata  <= dreq.data;
    end
  end

  // A zero strobe leaves every byte untouched, i.e. a plain read.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (r_strobe[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  a_data_zero_when_idle : assert property (@(posedge clk) disable iff (reset)
    !dresp.data_ok |-> (dresp.data == '0));

  a_resp_one_cycle : assert property (@(posedge clk) disable iff (reset)
    (r_state == S_RESP) |=> (r_state == S_IDLE));

  a_no_accept_when_busy : assert property (@(posedge clk) disable iff (reset)
    busy |-> !dresp.addr_ok);

endmodule

// File: tb/tb_dbus_responder.sv
`timescale 1ns/1ps

module tb_dbus_responder;
  import dbus_pkg::*;

  logic       clk;
  logic       reset;
  dbus_req_t  dreq  [3];
  dbus_resp_t dresp [3];
  logic       busy  [3];

  // Instance 0: LATENCY 2, instance 1: LATENCY 0, instance 2: LATENCY 3.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dbus_responder #(
      .MEM_WORDS_LOG2(10),
      .LATENCY       ((g == 0) ? 2 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .dreq (dreq[g]),
      .dresp(dresp[g]),
      .busy (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [31:0] d;
    bit          chk;
  } exp_t;

  exp_t sb [$];
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   acc_cyc [3];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[k] && n < 30);
    check("idle_within_bound", 32'(busy[k]), 32'd0);
  endtask

  // One request on instance k; expectation goes to the scoreboard, the
  // monitor compares it when data_ok shows up.
  task automatic do_req(input int k, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp_d, input bit chk);
    @(posedge clk); #1;
    dreq[k] = '{valid: 1'b1, addr: a, size: 3'd2, strobe: s, data: d};
    sb.push_back('{k: k, d: exp_d, chk: chk});
    @(negedge clk);
    check("addr_ok_same_cycle", 32'(dresp[k].addr_ok), 32'd1);
    @(posedge clk); #1;
    // Drop valid and scramble the other fields: the request must still complete untouched.
    dreq[k] = '{valid: 1'b0, addr: 32'h0000_03FC, size: 3'd7, strobe: 4'hF, data: 32'hFFFF_FFFF};
    wait_idle(k);
  endtask

  initial begin
    logic [5:0] pat_ok;
    logic [5:0] pat_busy;

    n_cmp   = 0;
    n_bad   = 0;
    cyc     = 0;
    acc_cyc = '{0, 0, 0};
    reset   = 1'b1;
    for (int k = 0; k < 3; k++) dreq[k] = '0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          cyc++;
          for (int k = 0; k < 3; k++) begin
            if (dresp[k].addr_ok) acc_cyc[k] = cyc;
            if (dresp[k].data_ok) begin
              if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_data_ok: inst %0d data_ok=1 required 0 (t=%0t)", k, $time);
              end else begin
                e = sb.pop_front();
                check("resp_instance", 32'(k), 32'(e.k));
                check("resp_latency", 32'(cyc - acc_cyc[k]), 32'(lat_of(k) + 1));
                if (e.chk) check("resp_data", dresp[k].data, e.d);
              end
            end else begin
              check("data_zero_without_data_ok", dresp[k].data, 32'd0);
            end
          end
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_busy", 32'(busy[k]), 32'd0);
      check("reset_flags", {30'd0, dresp[k].addr_ok, dresp[k].data_ok}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("post_reset_busy", 32'(busy[k]), 32'd0);

    // LATENCY 2: write then read, addr[1:0] ignored.
    do_req(0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_req(0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b1);
    do_req(0, 32'h0000_0013, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b1);

    // Byte strobes.
    do_req(0, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
    do_req(0, 32'h0000_0020, 4'h6, 32'hAABB_CCDD, 32'h1122_3344, 1'b1);
    do_req(0, 32'h0000_0020, 4'h0, 32'h0,         32'h11BB_CC44, 1'b1);

    // Read-before-write.
    do_req(0, 32'h0000_0030, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
    do_req(0, 32'h0000_0030, 4'hF, 32'h5555_5555, 32'h1234_5678, 1'b1);
    do_req(0, 32'h0000_0030, 4'h0, 32'h0,         32'h5555_5555, 1'b1);

    // LATENCY 0 with address wrap.
    do_req(1, 32'h0000_1004, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
    do_req(1, 32'h0000_0004, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b1);

    // LATENCY 0, valid held: accepted every second cycle.
    pat_ok = 6'b010101;
    @(posedge clk); #1;
    dreq[1] = '{valid: 1'b1, addr: 32'h0000_0004, size: 3'd2, strobe: 4'h0, data: 32'h0};
    repeat (3) sb.push_back('{k: 1, d: 32'hCAFE_F00D, chk: 1'b1});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("lat0_hold_addr_ok", 32'(dresp[1].addr_ok), 32'(pat_ok[i]));
      @(posedge clk); #1;
    end
    dreq[1].valid = 1'b0;
    wait_idle(1);

    // LATENCY 3, valid held for six cycles.
    do_req(2, 32'h0000_0040, 4'hF, 32'h0BAD_CAFE, 32'h0, 1'b0);
    pat_ok   = 6'b100001;
    pat_busy = 6'b011110;
    @(posedge clk); #1;
    dreq[2] = '{valid: 1'b1, addr: 32'h0000_0040, size: 3'd2, strobe: 4'h0, data: 32'h0};
    repeat (2) sb.push_back('{k: 2, d: 32'h0BAD_CAFE, chk: 1'b1});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("lat3_hold_addr_ok", 32'(dresp[2].addr_ok), 32'(pat_ok[i]));
      check("lat3_hold_busy", 32'(busy[2]), 32'(pat_busy[i]));
      @(posedge clk); #1;
    end
    dreq[2].valid = 1'b0;
    wait_idle(2);

    // Reset during WAIT drops a pending write; reset in IDLE refuses a request.
    do_req(2, 32'h0000_0050, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    @(posedge clk); #1;
    dreq[2] = '{valid: 1'b1, addr: 32'h0000_0050, size: 3'd2, strobe: 4'hF, data: 32'h0};
    @(negedge clk);
    check("drop_write_addr_ok", 32'(dresp[2].addr_ok), 32'd1);
    @(posedge clk); #1;
    dreq[2].valid = 1'b0;
    reset   = 1'b1;
    dreq[0] = '{valid: 1'b1, addr: 32'h0000_0010, size: 3'd2, strobe: 4'hF, data: 32'h0};
    @(negedge clk);
    check("reset_in_wait_busy", 32'(busy[2]), 32'd0);
    check("reset_in_wait_flags", {30'd0, dresp[2].addr_ok, dresp[2].data_ok}, 32'd0);
    check("reset_idle_addr_ok", 32'(dresp[0].addr_ok), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dreq[0].valid = 1'b0;
    @(negedge clk);
    check("after_reset_busy_wait_inst", 32'(busy[2]), 32'd0);
    check("after_reset_busy_idle_inst", 32'(busy[0]), 32'd0);
    repeat (6) @(negedge clk);
    do_req(2, 32'h0000_0050, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
    do_req(0, 32'h0000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
